// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the multi-channel byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_e;

  localparam logic [2:0]  LEN_1   = 3'd1;
  localparam logic [2:0]  LEN_2   = 3'd2;
  localparam logic [2:0]  LEN_4   = 3'd4;
  localparam logic [19:0] IO_BASE = 20'h30000;

  // Anything that is not a 1- or 2-byte request is a word access.
  function automatic logic [2:0] len_norm(input logic [2:0] len);
    case (len)
      LEN_1:   return LEN_1;
      LEN_2:   return LEN_2;
      default: return LEN_4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_nch_if.sv
// Request/response channels plus byte-wide memory bus of mem_ctrl_nch.
interface mem_ctrl_nch_if #(parameter int NCH = 3, parameter int AW = 32);
  logic                    rdy;
  logic [NCH-1:0]          req_valid;
  logic [NCH-1:0]          req_wr;
  logic [NCH-1:0][AW-1:0]  req_addr;
  logic [NCH-1:0][31:0]    req_data;
  logic [NCH-1:0][2:0]     req_len;
  logic [NCH-1:0]          flush;
  logic [NCH-1:0]          resp_valid;
  logic [31:0]             resp_data;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [AW-1:0]           mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  modport master (output rdy, req_valid, req_wr, req_addr, req_data, req_len, flush,
                         mem_din, io_buffer_full,
                  input  resp_valid, resp_data, mem_dout, mem_a, mem_wr);
  modport slave  (input  rdy, req_valid, req_wr, req_addr, req_data, req_len, flush,
                         mem_din, io_buffer_full,
                  output resp_valid, resp_data, mem_dout, mem_a, mem_wr);
endinterface

// File: rtl/mem_ctrl_nch_rr_arbiter.sv
// Round-robin request picker; search starts one past the last accepted grant.
module rr_arbiter #(
    parameter int NCH = 3,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic [NCH-1:0] i_req,
    output logic [NCH-1:0] o_gnt,
    output logic [IW-1:0]  o_idx
);
    logic [IW-1:0] r_last;
    logic          w_found;
    int            w_c;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int i = 1; i <= NCH; i++) begin
            w_c = int'(r_last) + i;
            if (w_c >= NCH) w_c = w_c - NCH;
            if (!w_found && i_req[w_c]) begin
                w_found    = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = IW'(w_c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 r_last <= IW'(NCH - 1);
        else if (i_en && w_found) r_last <= o_idx;
    end
endmodule

// File: rtl/mem_ctrl_nch.sv
// N-channel request arbiter driving a byte-serial memory port (reads and writes of 1/2/4 bytes).
// Optional IO_STALL_EN: writes into the IO window wait while io_buffer_full is high.
module mem_ctrl_nch
    import mem_ctrl_pkg::*;
#(
    parameter int NCH = 3,
    parameter int AW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_ctrl_nch_if.slave  bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_e          r_state, w_state_nxt;
    logic [IW-1:0]   r_ch, w_gnt_idx;
    logic [NCH-1:0]  w_gnt;
    logic            w_gnt_any;
    logic [AW-1:0]   r_base, w_cur_a, r_mem_a;
    logic [31:0]     r_wdata, r_rdata;
    logic [2:0]      r_len, r_cnt;
    logic [1:0]      w_rlane;
    logic            r_flushed, w_rd_last, w_wr_last, w_io_stall;
    logic [NCH-1:0]  r_resp;
    logic [7:0]      r_mem_dout;
    logic            r_mem_wr;

    rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (bus.rdy && r_state == ST_IDLE),
        .i_req (bus.req_valid & ~bus.flush),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    assign w_gnt_any = |w_gnt;
    assign w_cur_a   = r_base + AW'(r_cnt);
    assign w_rlane   = 2'(r_cnt - 3'd2);
    // Read data trails its address by two edges, so reads need one extra cycle.
    assign w_rd_last = (r_cnt == r_len + 3'd1);
    assign w_wr_last = (r_cnt == r_len);

`ifdef IO_STALL_EN
    assign w_io_stall = bus.io_buffer_full && (w_cur_a[17:16] == IO_BASE[17:16]);
`else
    assign w_io_stall = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_any) w_state_nxt = bus.req_wr[w_gnt_idx] ? ST_WR : ST_RD;
            ST_RD:   if (w_rd_last) w_state_nxt = ST_IDLE;
            ST_WR:   if (w_wr_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_state <= ST_IDLE;
        else if (bus.rdy) r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch <= '0; r_base <= '0; r_wdata <= '0; r_len <= LEN_4; r_cnt <= '0;
            r_flushed <= 1'b0; r_rdata <= '0; r_resp <= '0;
            r_mem_a <= '0; r_mem_dout <= '0; r_mem_wr <= 1'b0;
        end else if (bus.rdy) begin
            r_resp   <= '0;
            r_mem_wr <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_gnt_any) begin
                    r_ch      <= w_gnt_idx;
                    r_base    <= bus.req_addr[w_gnt_idx];
                    r_wdata   <= bus.req_data[w_gnt_idx];
                    r_len     <= len_norm(bus.req_len[w_gnt_idx]);
                    r_cnt     <= '0;
                    r_flushed <= 1'b0;
                    r_rdata   <= '0;
                end
                ST_RD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < r_len) r_mem_a <= w_cur_a;
                    if (r_cnt >= 3'd2) r_rdata[{w_rlane, 3'b000} +: 8] <= bus.mem_din;
                    if (bus.flush[r_ch]) r_flushed <= 1'b1;
                    if (w_rd_last && !(r_flushed || bus.flush[r_ch])) r_resp[r_ch] <= 1'b1;
                end
                ST_WR: begin
                    if (r_cnt < r_len) begin
                        if (!w_io_stall) begin
                            r_mem_a    <= w_cur_a;
                            r_mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                            r_mem_wr   <= 1'b1;
                            r_cnt      <= r_cnt + 3'd1;
                        end
                    end else begin
                        r_resp[r_ch] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A low rdy masks the strobes; the registers behind them simply hold.
    assign bus.resp_valid = r_resp & {NCH{bus.rdy}};
    assign bus.resp_data  = (|bus.resp_valid) ? r_rdata : 32'd0;
    assign bus.mem_wr     = r_mem_wr & bus.rdy;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_dout   = r_mem_dout;
endmodule

// File: tb/tb_mem_ctrl_nch.sv
// Directed scoreboard bench for mem_ctrl_nch (NCH=3): responses and write strobes are checked by monitors.
module tb_mem_ctrl_nch;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct { logic [2:0] vld; logic [31:0] data; int cyc; } resp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  logic [7:0] mem [0:1023];

  mem_ctrl_nch_if #(.NCH(3), .AW(32)) bus();
  mem_ctrl_nch #(.NCH(3), .AW(32)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory; it freezes together with the controller when rdy is low.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22;
      mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
      mem[10'h3FF] <= 8'hA5; mem[10'h000] <= 8'h5A;
    end else if (bus.rdy) begin
      if (bus.mem_wr) mem[bus.mem_a[9:0]] <= bus.mem_dout;
      bus.mem_din <= mem[bus.mem_a[9:0]];
    end
  end

  always @(negedge clk) begin
    resp_t r;
    wr_t   w;
    if (bus.resp_valid != 3'b000) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected cyc=%0d got vld=%b data=%h required none", cyc, bus.resp_valid, bus.resp_data);
      end else begin
        r = rq.pop_front();
        if (bus.resp_valid !== r.vld || bus.resp_data !== r.data || cyc != r.cyc) begin
          errors++;
          $display("FAIL resp got vld=%b data=%h cyc=%0d required vld=%b data=%h cyc=%0d",
                   bus.resp_valid, bus.resp_data, cyc, r.vld, r.data, r.cyc);
        end
      end
    end
    if (bus.mem_wr === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d got a=%h d=%h required none", cyc, bus.mem_a, bus.mem_dout);
      end else begin
        w = wq.pop_front();
        if (bus.mem_a !== w.a || bus.mem_dout !== w.d || cyc != w.cyc) begin
          errors++;
          $display("FAIL write got a=%h d=%h cyc=%0d required a=%h d=%h cyc=%0d",
                   bus.mem_a, bus.mem_dout, cyc, w.a, w.d, w.cyc);
        end
      end
    end
  end

  task automatic exp_resp(input int ch, input logic [31:0] d, input int c);
    resp_t r;
    r.vld = 3'b000; r.vld[ch] = 1'b1; r.data = d; r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.a = a; w.d = d; w.cyc = c;
    wq.push_back(w);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic issue(input int ch, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] len);
    bus.req_wr[ch] = wr; bus.req_addr[ch] = a; bus.req_data[ch] = d;
    bus.req_len[ch] = len; bus.req_valid[ch] = 1'b1;
  endtask

  // Requester: hold the request until its own resp_valid, bounded by a cycle budget.
  task automatic req_txn(input int ch, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] len);
    bit got;
    got = 1'b0;
    issue(ch, wr, a, d, len);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid[ch]) got = 1'b1;
    end
    #1 bus.req_valid[ch] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout ch%0d got no resp_valid required one within 60 cycles", ch);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0; bus.rdy = 1'b1; bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_len = '0; bus.flush = '0; bus.io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data",  bus.resp_data, 32'd0);
    check("rst_mem_wr",     32'(bus.mem_wr), 32'd0);
    check("rst_mem_a",      bus.mem_a, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // ch1 read of 4 bytes: response six cycles after the grant edge
    c = cyc; exp_resp(1, 32'h44332211, c + 7);
    req_txn(1, 1'b0, 32'h100, 32'h0, 3'd4);
    @(posedge clk); #2;

    // ch0 halfword write, little-endian byte order
    c = cyc; exp_wr(32'h200, 8'hEF, c + 2); exp_wr(32'h201, 8'hBE, c + 3); exp_resp(0, 32'h0, c + 4);
    req_txn(0, 1'b1, 32'h200, 32'h0000BEEF, 3'd2);
    @(posedge clk); #2;

    // ch2 halfword read across the top of the address space
    c = cyc; exp_resp(2, 32'h00005AA5, c + 5);
    req_txn(2, 1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2);
    @(posedge clk); #2;

    // all three channels busy, last grant was ch2: order 0,1,2,0 back-to-back
    c = cyc;
    exp_wr(32'h300, 8'hA0, c + 2);  exp_resp(0, 32'h0, c + 3);
    exp_wr(32'h301, 8'hB1, c + 5);  exp_resp(1, 32'h0, c + 6);
    exp_wr(32'h302, 8'hC2, c + 8);  exp_resp(2, 32'h0, c + 9);
    exp_wr(32'h303, 8'hD3, c + 11); exp_resp(0, 32'h0, c + 12);
    fork
      begin req_txn(0, 1'b1, 32'h300, 32'hA0, 3'd1); req_txn(0, 1'b1, 32'h303, 32'hD3, 3'd1); end
      req_txn(1, 1'b1, 32'h301, 32'hB1, 3'd1);
      req_txn(2, 1'b1, 32'h302, 32'hC2, 3'd1);
    join
    @(posedge clk); #2;

    // ch2 read flushed mid-flight: full bus sequence, no ch2 response, ch0 next
    c = cyc; exp_resp(0, 32'h00000022, c + 11);
    fork
      req_txn(0, 1'b0, 32'h101, 32'h0, 3'd1);
      begin
        issue(2, 1'b0, 32'h100, 32'h0, 3'd4);
        repeat (2) @(posedge clk);
        #2 bus.flush[2] = 1'b1; bus.req_valid[2] = 1'b0;
        @(posedge clk);
        #2 bus.flush[2] = 1'b0;
      end
    join
    @(posedge clk); #2;

    // rdy low for 3 cycles mid-read delays the response by exactly 3
    c = cyc; exp_resp(1, 32'h44332211, c + 10);
    fork
      req_txn(1, 1'b0, 32'h100, 32'h0, 3'd4);
      begin
        repeat (3) @(posedge clk);
        #2 bus.rdy = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.rdy = 1'b1;
      end
    join
    @(posedge clk); #2;

    // len 3 behaves as a word read
    c = cyc; exp_resp(2, 32'h44332211, c + 7);
    req_txn(2, 1'b0, 32'h100, 32'h0, 3'd3);
    @(posedge clk); #2;

    // len 0 word write; request fields changed after the grant are ignored
    c = cyc;
    exp_wr(32'h400, 8'h04, c + 2); exp_wr(32'h401, 8'h03, c + 3);
    exp_wr(32'h402, 8'h02, c + 4); exp_wr(32'h403, 8'h01, c + 5); exp_resp(0, 32'h0, c + 6);
    fork
      req_txn(0, 1'b1, 32'h400, 32'h01020304, 3'd0);
      begin
        @(posedge clk);
        #2 bus.req_data[0] = 32'hDEADBEEF; bus.req_addr[0] = 32'h777;
      end
    join
    @(posedge clk); #2;

    // IO-window byte write while the UART buffer reports full for 5 cycles
    c = cyc;
`ifdef IO_STALL_EN
    exp_wr(32'h30000, 8'h7E, c + 6); exp_resp(1, 32'h0, c + 7);
`else
    exp_wr(32'h30000, 8'h7E, c + 2); exp_resp(1, 32'h0, c + 3);
`endif
    bus.io_buffer_full = 1'b1;
    fork
      req_txn(1, 1'b1, 32'h30000, 32'h7E, 3'd1);
      begin
        repeat (5) @(posedge clk);
        #2 bus.io_buffer_full = 1'b0;
      end
    join
    @(posedge clk); #2;

    // reset in the middle of a read: outputs clear at once, nothing completes afterwards
    issue(2, 1'b0, 32'h100, 32'h0, 3'd4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0; bus.req_valid[2] = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_resp_data",  bus.resp_data, 32'd0);
    check("midrst_mem_wr",     32'(bus.mem_wr), 32'd0);
    check("midrst_mem_a",      bus.mem_a, 32'd0);
    check("midrst_mem_dout",   32'(bus.mem_dout), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    check("resp_queue_left",  rq.size(), 32'd0);
    check("write_queue_left", wq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_nch.md
MEM_CTRL_NCH -- requirements
Module: mem_ctrl_nch

Interface
REQ-001 SHALL have parameter NCH, default 3: number of requestor channels, range 2..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global ready; low freezes the block.
REQ-006 SHALL have port req_valid  input  NCH  per-channel request; held high until that channel's resp_valid.
REQ-007 SHALL have port req_wr  input  NCH  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  NCH*AW  per-channel byte address.
REQ-009 SHALL have port req_data  input  NCH*32  per-channel write data, little-endian.
REQ-010 SHALL have port req_len  input  NCH*3  byte count: 1, 2 or 4.
REQ-011 SHALL have port flush  input  NCH  per-channel squash, e.g. from rollback.
REQ-012 SHALL have port resp_valid  output  NCH  one-cycle completion pulse.
REQ-013 SHALL have port resp_data  output  32  read data, zero-extended; shared by all channels.
REQ-014 SHALL have port mem_din  input  8  memory read byte.
REQ-015 SHALL have port mem_dout  output  8  memory write byte.
REQ-016 SHALL have port mem_a  output  AW  memory byte address.
REQ-017 SHALL have port mem_wr  output  1  1 = write strobe.
REQ-018 SHALL have port io_buffer_full  input  1  UART buffer full.

Function
REQ-019 SHALL implement FSM with states IDLE, RD, WR.
REQ-020 SHALL, in IDLE, grant one valid, unflushed channel per cycle, round-robin, searching from last_grant+1 mod NCH.
REQ-021 SHALL latch addr, data, len and wr of the granted channel at grant; later changes to the request SHALL be ignored.
REQ-022 SHALL, for a read of L bytes, drive mem_a = base+k with mem_wr=0 for k=0..L-1 on consecutive cycles.
REQ-023 SHALL capture mem_din one cycle after each address into byte lane k.
REQ-024 SHALL assert resp_valid exactly L+2 cycles after the grant edge for reads.
REQ-025 SHALL, for a write, drive mem_wr=1, mem_a=base+k and mem_dout=data[8k+7:8k] for k=0..L-1.
REQ-026 SHALL assert resp_valid L+1 cycles after the grant edge for writes.
REQ-027 SHALL keep resp_data valid only during the resp_valid cycle; resp_valid SHALL be one-hot or zero.
REQ-028 SHALL return to IDLE in the resp_valid cycle and SHALL be able to grant a new request on that same edge (back-to-back).
REQ-029 SHALL treat req_len values other than 1 or 2 as 4.
REQ-030 SHALL address bytes with AW-bit wrap-around: base+k modulo 2^AW.
REQ-031 SHALL drive mem_wr=0 and hold mem_a at its last value when not transferring.
REQ-032 SHALL, on flush[i] during an in-flight read of channel i, finish the bus sequence and suppress resp_valid[i].
REQ-033 SHALL complete in-flight writes and assert resp_valid regardless of flush.
REQ-034 SHALL make flush[i] mask channel i from arbitration in that cycle.
REQ-035 SHALL, when rdy=0, hold all state and counters and force mem_wr=0; resp_valid SHALL not pulse.

Reset
REQ-036 SHALL, on rst low, immediately set state=IDLE, last_grant=NCH-1, resp_valid=0, resp_data=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-037 SHALL abandon an in-flight transaction on reset mid-operation, with no resp_valid after release.

Configuration
REQ-038 SHALL, with IO_STALL_EN defined, hold a write byte whose address has bits [17:16]=2'b11 while io_buffer_full=1: byte counter frozen, mem_wr=0.
REQ-039 SHALL issue such a write byte on the first cycle io_buffer_full=0, with IO_STALL_EN defined.
REQ-040 SHALL, without IO_STALL_EN, ignore io_buffer_full.

Structure
REQ-041 SHALL take FSM state enum, len encodings and the IO base constant 0x30000 from shared package mem_ctrl_pkg.
REQ-042 SHALL place round-robin selection in sub-module rr_arbiter, parameterised by NCH.

Verification
REQ-043 SHALL cover: NCH=3, ch1 read len4 @0x100 with memory bytes 11,22,33,44 -> resp_valid[1] at grant+6, resp_data=0x44332211.
REQ-044 SHALL cover: ch0 write len2 @0x200, data 0xBEEF -> bytes EF@0x200 then BE@0x201, mem_wr high 2 cycles, resp_valid[0] at grant+3.
REQ-045 SHALL cover: all 3 channels requesting continuously, last_grant=2 -> grant order 0,1,2,0 with back-to-back grants.
REQ-046 SHALL cover: flush[2] mid-read of ch2 -> all bytes still issued, no resp_valid[2], ch0 granted next.
REQ-047 SHALL cover: with IO_STALL_EN, write len1 @0x30000 and io_buffer_full high 5 cycles -> mem_wr rises on the cycle after full falls, resp_valid 1 cycle later.
REQ-048 SHALL cover: rdy low 3 cycles mid-read -> response delayed exactly 3 cycles with data unchanged.
REQ-049 SHALL cover: rst mid-transaction -> outputs zero immediately and no resp_valid after release.
